// File: rtl/pointwise_conv_sched_if.sv
// Bus bundle for the pointwise conv tile scheduler.
// Parameters are the layer geometry. The derived widths are computed here so that every user agrees on them.
// master : layer sequencer / bench side.
//          Drives start, load_w, the weight stream and psum_ready.
// slave  : the scheduler.
//          Drives busy/done, the weight-store write port, block selects, activation reads,
//          MAC controls and the psum handshake.
interface pointwise_conv_sched_if #(
  parameter int DATA_W   = 8,
  parameter int CIN      = 32,
  parameter int COUT     = 64,
  parameter int PAR_CIN  = 8,
  parameter int PAR_COUT = 8,
  parameter int NUM_PIX  = 16
);
  localparam int NCB = (CIN + PAR_CIN - 1) / PAR_CIN;
  localparam int NOB = (COUT + PAR_COUT - 1) / PAR_COUT;
  localparam int NW  = COUT * CIN;
  localparam int AW  = (NW > 1) ? $clog2(NW) : 1;
  localparam int CBW = (NCB > 1) ? $clog2(NCB) : 1;
  localparam int OBW = (NOB > 1) ? $clog2(NOB) : 1;
  localparam int PXW = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;

  logic              start, load_w, busy, done;
  logic              w_valid, w_ready;
  logic [DATA_W-1:0] w_data;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [OBW-1:0]    cout_blk_idx;
  logic [CBW-1:0]    cin_blk_idx;
  logic              act_rd_en;
  logic [PXW-1:0]    act_pix;
  logic              mac_en, mac_clr, mac_last;
  logic              psum_valid, psum_ready;
  logic [PXW-1:0]    psum_pix;
  logic [OBW-1:0]    psum_cout_blk;

  modport master (
    output start, load_w, w_valid, w_data, psum_ready,
    input  busy, done, w_ready, wr_en, wr_addr, wr_data, cout_blk_idx, cin_blk_idx,
           act_rd_en, act_pix, mac_en, mac_clr, mac_last, psum_valid, psum_pix, psum_cout_blk
  );

  modport slave (
    input  start, load_w, w_valid, w_data, psum_ready,
    output busy, done, w_ready, wr_en, wr_addr, wr_data, cout_blk_idx, cin_blk_idx,
           act_rd_en, act_pix, mac_en, mac_clr, mac_last, psum_valid, psum_pix, psum_cout_blk
  );
endinterface

// File: rtl/pointwise_conv_sched.sv
// Tile scheduler for the 1x1 convolution datapath.
//
// Phase 1 is optional. It streams COUT*CIN weights into the blocked weight store over a linear write port.
// Phase 2 sweeps pixel (outer), cout block (middle) and cin block (inner).
// It drives the block selects and the activation reads.
// MAC controls lag the issue by one cycle, matching the 1-cycle read latency.
// Each finished partial-sum block is handed downstream on a valid/ready handshake.
//
// Ports:
//   clk, rst : clock, async active-high reset.
//   bus      : pointwise_conv_sched_if.slave.
//              Carries start/load_w/busy/done, the weight stream,
//              the weight-store write port, block selects, activation read,
//              MAC controls and the psum handshake.
module pointwise_conv_sched #(
  parameter int DATA_W   = 8,
  parameter int CIN      = 32,
  parameter int COUT     = 64,
  parameter int PAR_CIN  = 8,
  parameter int PAR_COUT = 8,
  parameter int NUM_PIX  = 16
) (
  input logic clk,
  input logic rst,
  pointwise_conv_sched_if.slave bus
);
  localparam int NCB = (CIN + PAR_CIN - 1) / PAR_CIN;
  localparam int NOB = (COUT + PAR_COUT - 1) / PAR_COUT;
  localparam int NW  = COUT * CIN;
  localparam int AW  = (NW > 1) ? $clog2(NW) : 1;
  localparam int CBW = (NCB > 1) ? $clog2(NCB) : 1;
  localparam int OBW = (NOB > 1) ? $clog2(NOB) : 1;
  localparam int PXW = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;

  localparam logic [AW-1:0]  W_LAST  = AW'(NW - 1);
  localparam logic [CBW-1:0] CB_LAST = CBW'(NCB - 1);
  localparam logic [OBW-1:0] OB_LAST = OBW'(NOB - 1);
  localparam logic [PXW-1:0] PX_LAST = PXW'(NUM_PIX - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_ISSUE, S_WAIT_PS, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wcnt_q, wcnt_d;
  logic [CBW-1:0]    cb_q, cb_d;
  logic [OBW-1:0]    ob_q, ob_d;
  logic [PXW-1:0]    px_q, px_d;
  logic              wr_en_q;
  logic [AW-1:0]     wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              mac_en_q, mac_clr_q, mac_last_q;
  logic              ps_dly_q, psv_q;

  logic w_hs, issue, last_cb, ps_hs;

  assign w_hs    = (state_q == S_LOAD) && bus.w_valid;
  assign issue   = (state_q == S_ISSUE);
  assign last_cb = (cb_q == CB_LAST);
  assign ps_hs   = psv_q && bus.psum_ready;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    cb_d    = cb_q;
    ob_d    = ob_q;
    px_d    = px_q;
    unique case (state_q)
      S_IDLE: if (bus.start) begin
        wcnt_d  = '0;
        cb_d    = '0;
        ob_d    = '0;
        px_d    = '0;
        state_d = bus.load_w ? S_LOAD : S_ISSUE;
      end
      S_LOAD: if (bus.w_valid) begin
        if (wcnt_q == W_LAST) begin
          wcnt_d  = '0;
          state_d = S_SETTLE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      // Gap cycle so the last registered write lands before the first block read.
      S_SETTLE: state_d = S_ISSUE;
      S_ISSUE: begin
        if (last_cb) begin
          cb_d    = '0;
          state_d = S_WAIT_PS;
        end else begin
          cb_d = cb_q + 1'b1;
        end
      end
      S_WAIT_PS: if (ps_hs) begin
        state_d = S_ISSUE;
        if (ob_q == OB_LAST) begin
          ob_d = '0;
          if (px_q == PX_LAST) begin
            px_d    = '0;
            state_d = S_DONE;
          end else begin
            px_d = px_q + 1'b1;
          end
        end else begin
          ob_d = ob_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      cb_q       <= '0;
      ob_q       <= '0;
      px_q       <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      mac_en_q   <= 1'b0;
      mac_clr_q  <= 1'b0;
      mac_last_q <= 1'b0;
      ps_dly_q   <= 1'b0;
      psv_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      cb_q    <= cb_d;
      ob_q    <= ob_d;
      px_q    <= px_d;
      wr_en_q <= w_hs;
      if (w_hs) begin
        wr_addr_q <= wcnt_q;
        wr_data_q <= bus.w_data;
      end
      // MAC controls track the issue one cycle later (read latency).
      mac_en_q   <= issue;
      mac_clr_q  <= issue && (cb_q == '0);
      mac_last_q <= issue && last_cb;
      // The psum is ready one cycle after the last accumulate.
      ps_dly_q <= issue && last_cb;
      if (ps_hs)         psv_q <= 1'b0;
      else if (ps_dly_q) psv_q <= 1'b1;
    end
  end

  assign bus.busy          = (state_q != S_IDLE);
  assign bus.done          = (state_q == S_DONE);
  assign bus.w_ready       = (state_q == S_LOAD);
  assign bus.wr_en         = wr_en_q;
  assign bus.wr_addr       = wr_addr_q;
  assign bus.wr_data       = wr_data_q;
  assign bus.cout_blk_idx  = issue ? ob_q : '0;
  assign bus.cin_blk_idx   = issue ? cb_q : '0;
  assign bus.act_rd_en     = issue;
  assign bus.act_pix       = issue ? px_q : '0;
  assign bus.mac_en        = mac_en_q;
  assign bus.mac_clr       = mac_clr_q;
  assign bus.mac_last      = mac_last_q;
  assign bus.psum_valid    = psv_q;
  assign bus.psum_pix      = psv_q ? px_q : '0;
  assign bus.psum_cout_blk = psv_q ? ob_q : '0;
endmodule

// File: tb/tb_pointwise_conv_sched.sv
// Directed bench for pointwise_conv_sched.
// Configuration: CIN=COUT=16, PAR_*=8 (NCB=NOB=2), NW=256, NUM_PIX=2.
module tb_pointwise_conv_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pointwise_conv_sched_if #(.DATA_W(8), .CIN(16), .COUT(16), .PAR_CIN(8), .PAR_COUT(8), .NUM_PIX(2)) bus ();

  pointwise_conv_sched #(.DATA_W(8), .CIN(16), .COUT(16), .PAR_CIN(8), .PAR_COUT(8), .NUM_PIX(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Field order: busy, done, act_rd_en, cout_blk, cin_blk, act_pix, mac_en, mac_clr, mac_last,
  // psum_valid, psum_pix, psum_cout_blk.
  function automatic logic [11:0] pk(input logic bz, dn, ar, co, ci, ap, me, mc, ml, pv, pp, po);
    return {bz, dn, ar, co, ci, ap, me, mc, ml, pv, pp, po};
  endfunction

  function automatic logic [11:0] obs_vec();
    return pk(bus.busy, bus.done, bus.act_rd_en, bus.cout_blk_idx, bus.cin_blk_idx, bus.act_pix,
              bus.mac_en, bus.mac_clr, bus.mac_last, bus.psum_valid, bus.psum_pix, bus.psum_cout_blk);
  endfunction

  function automatic logic [7:0] wd(input int i);
    return 8'((i * 7 + 3) & 255);
  endfunction

  // One compute sweep with load_w=0.
  // The psum of block stall_blk is held off for 5 cycles.
  // With poke set, start is also pulsed during an ISSUE cycle and on the DONE cycle.
  task automatic sweep(input string nm, input int stall_blk, input bit poke);
    logic px, ob;
    bus.load_w = 1'b0;
    bus.psum_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      px = 1'(b / 2);
      ob = 1'(b % 2);
      chk({nm, "_iss0"}, 32'(obs_vec()), 32'(pk(1,0,1,ob,0,px,0,0,0,0,0,0)));
      if (poke && b == 0) bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk({nm, "_iss1"}, 32'(obs_vec()), 32'(pk(1,0,1,ob,1,px,1,1,0,0,0,0)));
      tick();
      chk({nm, "_wait"}, 32'(obs_vec()), 32'(pk(1,0,0,0,0,0,1,0,1,0,0,0)));
      tick();
      if (b == stall_blk) begin
        bus.psum_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          chk({nm, "_stall"}, 32'(obs_vec()), 32'(pk(1,0,0,0,0,0,0,0,0,1,px,ob)));
          tick();
        end
        bus.psum_ready = 1'b1;
      end
      chk({nm, "_psum"}, 32'(obs_vec()), 32'(pk(1,0,0,0,0,0,0,0,0,1,px,ob)));
      tick();
    end
    chk({nm, "_done"}, 32'(obs_vec()), 32'(pk(1,1,0,0,0,0,0,0,0,0,0,0)));
    if (poke) bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({nm, "_idle0"}, 32'(obs_vec()), 32'h0);
    tick();
    chk({nm, "_idle1"}, 32'(obs_vec()), 32'h0);
  endtask

  initial begin
    bus.start = 1'b0; bus.load_w = 1'b0; bus.w_valid = 1'b0; bus.w_data = '0; bus.psum_ready = 1'b0;

    // Reset state.
    tick();
    chk("rst_outs", 32'({obs_vec(), bus.w_ready, bus.wr_en, bus.wr_addr}), 32'h0);
    chk("rst_wrdata", 32'(bus.wr_data), 32'h0);
    rst = 1'b0;

    // Reset mid-LOAD at wcnt=100.
    bus.start = 1'b1; bus.load_w = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("midld_busy", 32'({bus.busy, bus.w_ready}), 32'h3);
    bus.w_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.w_data = wd(i);
      tick();
    end
    chk("midld_addr", 32'({bus.wr_en, bus.wr_addr}), 32'h163);
    rst = 1'b1;
    #1;
    chk("midld_rst", 32'({obs_vec(), bus.w_ready, bus.wr_en, bus.wr_addr, bus.wr_data}), 32'h0);
    tick();
    rst = 1'b0;
    bus.w_valid = 1'b0;
    chk("midld_post", 32'({obs_vec(), bus.w_ready, bus.wr_en}), 32'h0);

    // Toggling w_valid; a fresh load restarts at address 0.
    bus.start = 1'b1; bus.load_w = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("tog_start", 32'({bus.w_ready, bus.wr_en}), 32'h2);
    bus.w_valid = 1'b1; bus.w_data = 8'hA1;
    tick();
    chk("tog_w0", 32'({bus.wr_en, bus.wr_addr, bus.wr_data}), {15'd0, 1'b1, 8'd0, 8'hA1});
    bus.w_valid = 1'b0; bus.w_data = 8'h77;
    tick();
    chk("tog_gap", 32'({bus.wr_en, bus.wr_addr, bus.wr_data}), {15'd0, 1'b0, 8'd0, 8'hA1});
    bus.w_valid = 1'b1; bus.w_data = 8'hB2;
    tick();
    chk("tog_w1", 32'({bus.wr_en, bus.wr_addr, bus.wr_data}), {15'd0, 1'b1, 8'd1, 8'hB2});
    bus.w_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Full weight load with w_valid held high (also high in IDLE, where it must be ignored).
    bus.w_valid = 1'b1; bus.w_data = 8'hEE; bus.start = 1'b1; bus.load_w = 1'b1; bus.psum_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("ld_idle_ign", 32'({bus.wr_en, bus.w_ready}), 32'h1);
    for (int i = 0; i < 256; i++) begin
      bus.w_data = wd(i);
      tick();
      chk("ld_write", 32'({bus.wr_en, bus.wr_addr, bus.wr_data}), {15'd0, 1'b1, 8'(i), wd(i)});
    end
    chk("ld_settle", 32'({bus.w_ready, bus.act_rd_en, bus.busy}), 32'h1);
    bus.w_valid = 1'b0;
    tick();
    chk("ld_first_iss", 32'({bus.wr_en, bus.act_rd_en, bus.cout_blk_idx, bus.cin_blk_idx}), 32'h4);
    begin
      int n = 0;
      while (!bus.done && n < 40) begin
        tick();
        n++;
      end
      chk("ld_run_done", 32'(bus.done), 32'h1);
    end
    tick();
    chk("ld_run_idle", 32'({bus.busy, bus.done}), 32'h0);

    // Compute-only sweeps.
    sweep("sw", -1, 1'b0);
    sweep("stall", 1, 1'b0);
    sweep("poke", -1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
